// File: rtl/cache_arbiter_if.sv
// Client and physical-memory bus shared by the I-cache, D-cache, arbiter and memory.
// The arbiter takes the slave view; the caches and memory together take the master view.
interface cache_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
);
  logic                  i_pmem_read;
  logic [ADDR_WIDTH-1:0] i_pmem_address;
  logic [LINE_WIDTH-1:0] i_pmem_rdata;
  logic                  i_pmem_resp;

  logic                  d_pmem_read;
  logic                  d_pmem_write;
  logic [ADDR_WIDTH-1:0] d_pmem_address;
  logic [LINE_WIDTH-1:0] d_pmem_wdata;
  logic [LINE_WIDTH-1:0] d_pmem_rdata;
  logic                  d_pmem_resp;

  logic                  pmem_read;
  logic                  pmem_write;
  logic [ADDR_WIDTH-1:0] pmem_address;
  logic [LINE_WIDTH-1:0] pmem_wdata;
  logic [LINE_WIDTH-1:0] pmem_rdata;
  logic                  pmem_resp;

  modport slave (
    input  i_pmem_read, i_pmem_address,
    input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    input  pmem_rdata, pmem_resp,
    output i_pmem_rdata, i_pmem_resp,
    output d_pmem_rdata, d_pmem_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport master (
    output i_pmem_read, i_pmem_address,
    output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    output pmem_rdata, pmem_resp,
    input  i_pmem_rdata, i_pmem_resp,
    input  d_pmem_rdata, d_pmem_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/cache_arbiter.sv
// Round-robin arbiter between I-cache fills and D-cache fills/writebacks onto one
// physical memory port; every bus output comes straight from a register.
module cache_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int LINE_WIDTH  = 256,
  parameter int OFFSET_BITS = 5
) (
  input logic           clk,
  input logic           rst,
  cache_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    RESP_I,
    RESP_D
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
    {{(ADDR_WIDTH-OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};

  state_e                state_q;
  logic                  last_grant_d_q;
  logic                  pmem_read_q;
  logic                  pmem_write_q;
  logic [ADDR_WIDTH-1:0] pmem_address_q;
  logic [LINE_WIDTH-1:0] pmem_wdata_q;
  logic [LINE_WIDTH-1:0] i_rdata_q;
  logic [LINE_WIDTH-1:0] d_rdata_q;
  logic                  i_resp_q;
  logic                  d_resp_q;

  logic                  i_req_d;
  logic                  d_req_d;
  logic                  grant_i_d;
  logic                  grant_d_d;
  logic [ADDR_WIDTH-1:0] i_line_addr_d;
  logic [ADDR_WIDTH-1:0] d_line_addr_d;

  // On a tie the client that did not win last time goes first.
  always_comb begin
    i_req_d       = bus.i_pmem_read;
    d_req_d       = bus.d_pmem_read | bus.d_pmem_write;
    grant_i_d     = i_req_d & (~d_req_d | last_grant_d_q);
    grant_d_d     = d_req_d & ~grant_i_d;
    i_line_addr_d = bus.i_pmem_address & LINE_MASK;
    d_line_addr_d = bus.d_pmem_address & LINE_MASK;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      last_grant_d_q <= 1'b1;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
      pmem_wdata_q   <= '0;
      i_rdata_q      <= '0;
      d_rdata_q      <= '0;
      i_resp_q       <= 1'b0;
      d_resp_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_i_d) begin
            state_q        <= SERVE_I;
            pmem_address_q <= i_line_addr_d;
            pmem_read_q    <= 1'b1;
            pmem_write_q   <= 1'b0;
          end else if (grant_d_d) begin
            // A simultaneous read and write from the D-cache is taken as a writeback.
            state_q        <= SERVE_D;
            pmem_address_q <= d_line_addr_d;
            pmem_read_q    <= ~bus.d_pmem_write;
            pmem_write_q   <= bus.d_pmem_write;
            if (bus.d_pmem_write) begin
              pmem_wdata_q <= bus.d_pmem_wdata;
            end
          end
        end
        SERVE_I: begin
          if (bus.pmem_resp) begin
            state_q        <= RESP_I;
            pmem_read_q    <= 1'b0;
            pmem_write_q   <= 1'b0;
            i_rdata_q      <= bus.pmem_rdata;
            i_resp_q       <= 1'b1;
            last_grant_d_q <= 1'b0;
          end
        end
        SERVE_D: begin
          if (bus.pmem_resp) begin
            state_q        <= RESP_D;
            pmem_read_q    <= 1'b0;
            pmem_write_q   <= 1'b0;
            if (pmem_read_q) begin
              d_rdata_q <= bus.pmem_rdata;
            end
            d_resp_q       <= 1'b1;
            last_grant_d_q <= 1'b1;
          end
        end
        RESP_I: begin
          state_q  <= IDLE;
          i_resp_q <= 1'b0;
        end
        RESP_D: begin
          state_q  <= IDLE;
          d_resp_q <= 1'b0;
        end
        default: begin
          state_q      <= IDLE;
          pmem_read_q  <= 1'b0;
          pmem_write_q <= 1'b0;
          i_resp_q     <= 1'b0;
          d_resp_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pmem_read    = pmem_read_q;
  assign bus.pmem_write   = pmem_write_q;
  assign bus.pmem_address = pmem_address_q;
  assign bus.pmem_wdata   = pmem_wdata_q;
  assign bus.i_pmem_rdata = i_rdata_q;
  assign bus.i_pmem_resp  = i_resp_q;
  assign bus.d_pmem_rdata = d_rdata_q;
  assign bus.d_pmem_resp  = d_resp_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: stimulus pushes expected memory accesses and
// client responses into queues; a negedge monitor pops and compares them.
module tb_cache_arbiter;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [255:0] wdata;
  } mem_exp_t;

  typedef struct packed {
    logic        is_d;
    logic [255:0] rdata;
  } rsp_exp_t;

  logic clk;
  logic rst;

  cache_arbiter_if #(.ADDR_WIDTH(32), .LINE_WIDTH(256)) bus ();

  cache_arbiter #(.ADDR_WIDTH(32), .LINE_WIDTH(256), .OFFSET_BITS(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic         mdl_resp;
  logic         stray_resp;
  logic [255:0] mdl_rdata;
  logic         mdl_en;
  int           mdl_lat;
  logic         fixed_en;
  logic [255:0] fixed_line;

  assign bus.pmem_resp  = mdl_resp | stray_resp;
  assign bus.pmem_rdata = mdl_rdata;

  mem_exp_t mem_q[$];
  rsp_exp_t rsp_q[$];
  int n_vec;
  int n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_mem(input logic wr, input logic [31:0] addr, input logic [255:0] wdata);
    mem_exp_t e;
    e.wr = wr; e.addr = addr; e.wdata = wdata;
    mem_q.push_back(e);
  endtask

  task automatic push_rsp(input logic is_d, input logic [255:0] rdata);
    rsp_exp_t e;
    e.is_d = is_d; e.rdata = rdata;
    rsp_q.push_back(e);
  endtask

  task automatic wait_resp(input logic is_d);
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clk);
      if (is_d ? bus.d_pmem_resp : bus.i_pmem_resp) seen = 1'b1;
    end
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_resp_timeout: client_d=%0d got no response within 60 cycles", is_d);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    mem_q.delete();
    rsp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Memory model: answers any strobe after mdl_lat cycles with a one-cycle pmem_resp.
  initial begin
    int cnt;
    cnt = 0;
    mdl_resp = 1'b0;
    mdl_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst || !mdl_en) begin
        mdl_resp = 1'b0;
        cnt = 0;
      end else if (mdl_resp) begin
        mdl_resp = 1'b0;
      end else if (bus.pmem_read || bus.pmem_write) begin
        cnt++;
        if (cnt >= mdl_lat) begin
          mdl_resp = 1'b1;
          cnt = 0;
          if (bus.pmem_read) mdl_rdata = fixed_en ? fixed_line : {8{bus.pmem_address}};
        end
      end
    end
  end

  // Monitor
  initial begin
    logic prev_strobe;
    logic pending;
    logic strobe;
    mem_exp_t me;
    rsp_exp_t re;
    prev_strobe = 1'b0;
    pending = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_strobe = 1'b0;
        pending = 1'b0;
      end else begin
        if (pending) begin
          chk("resp_latency", {255'd0, bus.i_pmem_resp | bus.d_pmem_resp}, 256'd1);
          chk("strobe_drop", {255'd0, bus.pmem_read | bus.pmem_write}, 256'd0);
          pending = 1'b0;
        end
        strobe = bus.pmem_read | bus.pmem_write;
        if (strobe && !prev_strobe) begin
          if (mem_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_access: rd=%0d wr=%0d addr=%h, none expected",
                     bus.pmem_read, bus.pmem_write, bus.pmem_address);
          end else begin
            me = mem_q.pop_front();
            chk("mem_op", {254'd0, bus.pmem_read, bus.pmem_write}, {254'd0, ~me.wr, me.wr});
            chk("mem_addr", {224'd0, bus.pmem_address}, {224'd0, me.addr});
            if (me.wr) chk("mem_wdata", bus.pmem_wdata, me.wdata);
          end
        end
        prev_strobe = strobe;
        if (strobe && bus.pmem_resp) pending = 1'b1;
        if (bus.i_pmem_resp || bus.d_pmem_resp) begin
          if (rsp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_resp: i_resp=%0d d_resp=%0d, none expected",
                     bus.i_pmem_resp, bus.d_pmem_resp);
          end else begin
            re = rsp_q.pop_front();
            chk("resp_client", {254'd0, bus.d_pmem_resp, bus.i_pmem_resp},
                {254'd0, re.is_d, ~re.is_d});
            chk("resp_rdata", re.is_d ? bus.d_pmem_rdata : bus.i_pmem_rdata, re.rdata);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    logic [255:0] line_a5;
    logic [255:0] wd1;
    logic [255:0] wd2;
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    mdl_en = 1'b1;
    mdl_lat = 3;
    fixed_en = 1'b0;
    fixed_line = '0;
    stray_resp = 1'b0;
    bus.i_pmem_read = 1'b0;
    bus.i_pmem_address = '0;
    bus.d_pmem_read = 1'b0;
    bus.d_pmem_write = 1'b0;
    bus.d_pmem_address = '0;
    bus.d_pmem_wdata = '0;
    line_a5 = {32{8'hA5}};
    wd1 = {16{16'h1234}};
    wd2 = {32{8'h3C}};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_pmem_read", {255'd0, bus.pmem_read}, 256'd0);
    chk("rst_pmem_write", {255'd0, bus.pmem_write}, 256'd0);
    chk("rst_pmem_address", {224'd0, bus.pmem_address}, 256'd0);
    chk("rst_pmem_wdata", bus.pmem_wdata, 256'd0);
    chk("rst_i_rdata", bus.i_pmem_rdata, 256'd0);
    chk("rst_d_rdata", bus.d_pmem_rdata, 256'd0);
    chk("rst_resps", {254'd0, bus.i_pmem_resp, bus.d_pmem_resp}, 256'd0);

    // I-cache only, fixed A5 line
    fixed_en = 1'b1;
    fixed_line = line_a5;
    push_mem(1'b0, 32'h0000_1220, '0);
    push_rsp(1'b0, line_a5);
    bus.i_pmem_read = 1'b1;
    bus.i_pmem_address = 32'h0000_1234;
    @(posedge clk);
    #1;
    chk("i_strobe_latency", {255'd0, bus.pmem_read}, 256'd1);
    wait_resp(1'b0);
    bus.i_pmem_read = 1'b0;
    @(negedge clk);
    chk("i_only_d_rdata", bus.d_pmem_rdata, 256'd0);
    chk("i_only_i_rdata_hold", bus.i_pmem_rdata, line_a5);
    fixed_en = 1'b0;

    // Tie after reset: I, D, I
    do_reset();
    push_mem(1'b0, 32'h0000_0100, '0);
    push_rsp(1'b0, {8{32'h0000_0100}});
    push_mem(1'b0, 32'h0000_2040, '0);
    push_rsp(1'b1, {8{32'h0000_2040}});
    push_mem(1'b0, 32'h0000_3320, '0);
    push_rsp(1'b0, {8{32'h0000_3320}});
    bus.i_pmem_read = 1'b1;
    bus.i_pmem_address = 32'h0000_0110;
    bus.d_pmem_read = 1'b1;
    bus.d_pmem_address = 32'h0000_2040;
    wait_resp(1'b0);
    bus.i_pmem_address = 32'h0000_3333;
    wait_resp(1'b1);
    bus.d_pmem_read = 1'b0;
    wait_resp(1'b0);
    bus.i_pmem_read = 1'b0;

    // D writeback; d_rdata must keep the previous fill
    push_mem(1'b1, 32'h8000_00E0, wd1);
    push_rsp(1'b1, {8{32'h0000_2040}});
    @(negedge clk);
    bus.d_pmem_write = 1'b1;
    bus.d_pmem_address = 32'h8000_00FF;
    bus.d_pmem_wdata = wd1;
    @(posedge clk);
    #1;
    chk("d_write_latency", {254'd0, bus.pmem_read, bus.pmem_write}, 256'd1);
    wait_resp(1'b1);
    bus.d_pmem_write = 1'b0;

    // Read and write together: performed as write
    push_mem(1'b1, 32'h0000_0040, wd2);
    push_rsp(1'b1, {8{32'h0000_2040}});
    @(negedge clk);
    bus.d_pmem_read = 1'b1;
    bus.d_pmem_write = 1'b1;
    bus.d_pmem_address = 32'h0000_0044;
    bus.d_pmem_wdata = wd2;
    wait_resp(1'b1);
    bus.d_pmem_read = 1'b0;
    bus.d_pmem_write = 1'b0;
    @(negedge clk);
    chk("i_rdata_hold", bus.i_pmem_rdata, {8{32'h0000_3320}});

    // Reset in the middle of a D fill
    mdl_en = 1'b0;
    push_mem(1'b0, 32'h0000_0600, '0);
    bus.d_pmem_read = 1'b1;
    bus.d_pmem_address = 32'h0000_0600;
    @(posedge clk);
    #1;
    chk("d_read_latency", {254'd0, bus.pmem_read, bus.pmem_write}, 256'd2);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_pmem_read", {255'd0, bus.pmem_read}, 256'd0);
    chk("async_rst_resps", {254'd0, bus.i_pmem_resp, bus.d_pmem_resp}, 256'd0);
    chk("async_rst_address", {224'd0, bus.pmem_address}, 256'd0);
    chk("async_rst_i_rdata", bus.i_pmem_rdata, 256'd0);
    chk("async_rst_d_rdata", bus.d_pmem_rdata, 256'd0);
    chk("async_rst_wdata", bus.pmem_wdata, 256'd0);
    mem_q.delete();
    rsp_q.delete();
    bus.i_pmem_read = 1'b1;
    bus.i_pmem_address = 32'h0000_0500;
    push_mem(1'b0, 32'h0000_0500, '0);
    push_rsp(1'b0, {8{32'h0000_0500}});
    push_mem(1'b0, 32'h0000_0600, '0);
    push_rsp(1'b1, {8{32'h0000_0600}});
    mdl_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_resp(1'b0);
    bus.i_pmem_read = 1'b0;
    wait_resp(1'b1);
    bus.d_pmem_read = 1'b0;

    // Stray pmem_resp while idle
    @(negedge clk);
    stray_resp = 1'b1;
    @(negedge clk);
    stray_resp = 1'b0;
    chk("stray_no_resp", {254'd0, bus.i_pmem_resp, bus.d_pmem_resp}, 256'd0);
    chk("stray_no_strobe", {254'd0, bus.pmem_read, bus.pmem_write}, 256'd0);
    @(negedge clk);
    chk("stray_no_resp_late", {254'd0, bus.i_pmem_resp, bus.d_pmem_resp}, 256'd0);
    push_mem(1'b0, 32'h0000_0700, '0);
    push_rsp(1'b0, {8{32'h0000_0700}});
    bus.i_pmem_read = 1'b1;
    bus.i_pmem_address = 32'h0000_071F;
    @(posedge clk);
    #1;
    chk("post_stray_latency", {255'd0, bus.pmem_read}, 256'd1);
    wait_resp(1'b0);
    bus.i_pmem_read = 1'b0;
    repeat (3) @(negedge clk);

    chk("mem_q_drained", 256'(mem_q.size()), 256'd0);
    chk("rsp_q_drained", 256'(rsp_q.size()), 256'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
